// File: rtl/adder_seq_ctrl.sv
// Sequencing controller: WIDTH-bit add through one external 4-bit ripple slice, one nibble per cycle.
// Optional `SUBTRACT_EN adds a sub input that turns the operation into A-B.
module adder_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLOCK_50_B5B,
  input  logic             RESET,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_s,
  input  logic             slice_cout
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned CntW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  s_sh_q, s_sh_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic [WIDTH-1:0]  s_next;

`ifdef SUBTRACT_EN
  // Subtraction is A + ~B + 1; the caller's cin is ignored.
  assign b_eff   = sub ? ~op_b : op_b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = op_b;
  assign cin_eff = cin;
`endif

  if (WIDTH > 4) begin : g_wide
    assign s_next = {slice_s, s_sh_q[WIDTH-1:4]};
  end else begin : g_narrow
    assign s_next = slice_s;
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StRun: begin
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        s_sh_d  = s_next;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NSLICE - 1)) begin
          state_d = StDone;
          sum_d   = s_next;
          cout_d  = slice_cout;
          ovf_d   = (a_msb_q == b_msb_q) && (s_next[WIDTH-1] != a_msb_q);
        end
      end
      StDone:  state_d = StIdle;
      StIdle:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Start is honoured in IDLE and DONE; DONE may chain straight into RUN.
    if (start && (state_q != StRun)) begin
      state_d = StRun;
      a_sh_d  = op_a;
      b_sh_d  = b_eff;
      carry_d = cin_eff;
      cnt_d   = '0;
      a_msb_d = op_a[WIDTH-1];
      b_msb_d = b_eff[WIDTH-1];
    end
  end

  always_ff @(posedge CLOCK_50_B5B) begin
    if (RESET) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign slice_a   = busy ? a_sh_q[3:0] : 4'h0;
  assign slice_b   = busy ? b_sh_q[3:0] : 4'h0;
  assign slice_cin = busy ? carry_q : 1'b0;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: stimulus pushes expected results, a monitor checks on done.
// The external 4-bit slice is modelled here as a plain 5-bit addition.
module tb_adder_seq_ctrl;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  op_a, op_b;
  logic          cin;
  logic          sub;
  logic          busy, done, cout, ovf;
  logic [W-1:0]  sum;
  logic [3:0]    slice_a, slice_b, slice_s;
  logic          slice_cin, slice_cout;

  always #5 clk = ~clk;

  assign {slice_cout, slice_s} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

  adder_seq_ctrl #(.WIDTH(W)) dut (
    .CLOCK_50_B5B (clk),
    .RESET        (rst),
    .start        (start),
    .op_a         (op_a),
    .op_b         (op_b),
    .cin          (cin),
`ifdef SUBTRACT_EN
    .sub          (sub),
`endif
    .busy         (busy),
    .done         (done),
    .sum          (sum),
    .cout         (cout),
    .ovf          (ovf),
    .slice_a      (slice_a),
    .slice_b      (slice_b),
    .slice_cin    (slice_cin),
    .slice_s      (slice_s),
    .slice_cout   (slice_cout)
  );

  typedef struct {
    longint        a, b, c;
    logic [W-1:0]  sum;
    logic          cout, ovf;
    int            k;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   run_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: arithmetic on whole integers, with subtraction as A + ~B + 1.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    exp_t   e;
    longint bb, cc, full, sa, sb, r;
    bb   = s ? longint'(~b) : longint'(b);
    cc   = s ? 1 : longint'(c);
    full = longint'(a) + bb + cc;
    sa   = longint'($signed(a));
    sb   = longint'($signed(W'(bb)));
    r    = sa + sb + cc;
    e.a    = longint'(a);
    e.b    = bb;
    e.c    = cc;
    e.sum  = W'(full);
    e.cout = full[W];
    e.ovf  = (r > 32767) || (r < -32768);
    e.k    = 0;
    return e;
  endfunction

  // Monitor: slice traffic while busy, result and latency on done.
  always @(negedge clk) begin
    exp_t   e;
    longint mask, lo;
    int     i;
    if (busy) begin
      run_len++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL busy_unexpected: busy=1 required 0 (cycle %0d)", cyc);
      end else begin
        e    = q[0];
        i    = cyc - e.k;
        mask = (64'd1 << (4 * i)) - 1;
        lo   = (e.a & mask) + (e.b & mask) + e.c;
        chk("slice_a", slice_a, (e.a >> (4 * i)) & 15);
        chk("slice_b", slice_b, (e.b >> (4 * i)) & 15);
        chk("slice_cin", slice_cin, (lo >> (4 * i)) & 1);
      end
    end
    if (done) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: done=1 required 0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", cout, e.cout);
        chk("ovf", ovf, e.ovf);
        chk("done_latency", cyc - e.k, NSLICE);
        chk("busy_cycles", run_len, NSLICE);
      end
      run_len = 0;
    end
    if (!busy && !done) run_len = 0;
  end

  // Called at a negedge when the DUT is in IDLE or DONE.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s);
    exp_t e;
    op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef SUBTRACT_EN
    e = model(a, b, c, s);
`else
    e = model(a, b, c, 1'b0);
`endif
    e.k = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && q.size() != 0; n++) @(negedge clk);
    chk("drain_pending", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_cout"}, cout, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_slice_a"}, slice_a, 0);
    chk({tag, "_slice_b"}, slice_b, 0);
    chk({tag, "_slice_cin"}, slice_cin, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_zero("reset");

    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    drain();

    // Abort: start ignored in busy cycle 2, reset in busy cycle 3.
    issue(16'h1111, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #1;
    op_a = 16'hABCD; op_b = 16'h0F0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk_idle_zero("abort");
    repeat (6) @(negedge clk);
    issue(16'h1111, 16'h1111, 1'b0, 1'b0);
    drain();

    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    drain();
    issue(16'h0000, 16'h0000, 1'b1, 1'b0);
    drain();

    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    wait_done();
    issue(16'h8000, 16'h8000, 1'b0, 1'b0);
    drain();

`ifdef SUBTRACT_EN
    issue(16'h0005, 16'h0007, 1'b1, 1'b1);
    drain();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1);
    drain();
`endif

    for (int t = 0; t < 150; t++) begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      issue(ra, rb, rc, rs);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        op_a = W'($urandom); op_b = W'($urandom); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        wait_done();
      end else begin
        drain();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
